// File: rtl/plazer_mem_pkg.sv
// Shared types and helpers for the plazer dual-port Avalon-MM RAM.
package plazer_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int RD_LAT_MAX = 3;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/plazer_dpram_core.sv
// Behavioural true dual-port byte-enabled RAM with one registered raw read per port.
// A read sees the contents before any write landing on the same edge (old-data).
module plazer_dpram_core
  import plazer_mem_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 7,
  parameter INIT_FILE = "plazer_dpram_avmm.hex",
  localparam int BE_W = be_width(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_a_we,
  input  logic              i_a_re,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [BE_W-1:0]   i_a_be,
  input  logic [DATA_W-1:0] i_a_wd,
  output logic [DATA_W-1:0] o_a_q,
  input  logic              i_b_we,
  input  logic              i_b_re,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [BE_W-1:0]   i_b_be,
  input  logic [DATA_W-1:0] i_b_wd,
  output logic [DATA_W-1:0] o_b_q
);

  localparam int DEPTH = 2 ** ADDR_W;

  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] r_mem [DEPTH];

  // Same-address double writes are removed upstream by the arbiter.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (i_a_we && i_a_be[i]) r_mem[i_a_addr][i*8 +: 8] <= i_a_wd[i*8 +: 8];
      if (i_b_we && i_b_be[i]) r_mem[i_b_addr][i*8 +: 8] <= i_b_wd[i*8 +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_a_q <= '0;
      o_b_q <= '0;
    end else begin
      if (i_a_re) o_a_q <= r_mem[i_a_addr];
      if (i_b_re) o_b_q <= r_mem[i_b_addr];
    end
  end

endmodule

// File: rtl/plazer_dpram_avmm.sv
// Dual Avalon-MM slave RAM: acceptance, A-wins write arbitration, read pipelines.
// Define PLAZER_DPRAM_CLEAR_EN to build in the post-reset zero-fill sequencer.
module plazer_dpram_avmm
  import plazer_mem_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1,
  parameter INIT_FILE = "plazer_dpram_avmm.hex",
  localparam int BE_W = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic              a_chipselect,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  input  logic              a_clken,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  output logic              a_waitrequest,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic              b_chipselect,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  input  logic              b_clken,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic              b_waitrequest,
  output logic              busy
);

  localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);

  logic              w_busy, w_hold, w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_a_wr_cand, w_b_wr_cand, w_collide;
  logic              w_a_acc, w_b_acc, w_a_we, w_b_we;
  logic              w_ca_we;
  logic [ADDR_W-1:0] w_ca_addr;
  logic [BE_W-1:0]   w_ca_be;
  logic [DATA_W-1:0] w_ca_wd;
  logic [1:0]        w_ce, w_re, w_rvalid;
  logic [DATA_W-1:0] w_q [2];
  logic [DATA_W-1:0] w_rdata [2];

`ifdef PLAZER_DPRAM_CLEAR_EN
  clr_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= 1'b0;
      r_cnt   <= (r_state == CLEAR) ? r_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (r_pend) w_state_nxt = CLEAR;
      CLEAR: if (&r_cnt) w_state_nxt = IDLE;
    endcase
  end

  // Ports stay stalled from reset until the fill has finished.
  assign w_busy     = (r_state == CLEAR);
  assign w_hold     = w_busy | r_pend;
  assign w_clr_we   = w_busy;
  assign w_clr_addr = r_cnt;
`else
  assign w_busy     = 1'b0;
  assign w_hold     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign busy = w_busy;

  // Handshake: a request is taken on an edge where chipselect & (read|write) &
  // clken are high and waitrequest is low; a write wins over a read in the same request.
  assign w_a_wr_cand   = a_chipselect & a_write & a_clken & ~w_hold;
  assign w_b_wr_cand   = b_chipselect & b_write & b_clken & ~w_hold;
  assign w_collide     = w_a_wr_cand & w_b_wr_cand & (a_address == b_address);
  assign a_waitrequest = w_hold;
  assign b_waitrequest = w_hold | w_collide;

  assign w_a_acc = a_chipselect & (a_read | a_write) & a_clken & ~a_waitrequest;
  assign w_b_acc = b_chipselect & (b_read | b_write) & b_clken & ~b_waitrequest;
  assign w_a_we  = w_a_acc & a_write;
  assign w_b_we  = w_b_acc & b_write;
  assign w_re    = {w_b_acc & ~b_write, w_a_acc & ~a_write};
  assign w_ce    = {b_clken, a_clken};

  assign w_ca_we   = w_a_we | w_clr_we;
  assign w_ca_addr = w_clr_we ? w_clr_addr : a_address;
  assign w_ca_be   = w_clr_we ? '1 : a_byteenable;
  assign w_ca_wd   = w_clr_we ? '0 : a_writedata;

  plazer_dpram_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_a_we   (w_ca_we),
    .i_a_re   (w_re[0]),
    .i_a_addr (w_ca_addr),
    .i_a_be   (w_ca_be),
    .i_a_wd   (w_ca_wd),
    .o_a_q    (w_q[0]),
    .i_b_we   (w_b_we),
    .i_b_re   (w_re[1]),
    .i_b_addr (b_address),
    .i_b_be   (b_byteenable),
    .i_b_wd   (b_writedata),
    .o_b_q    (w_q[1])
  );

  // The core register is stage 0; data only advances alongside a valid so the
  // output holds its last value between reads, and clken low freezes everything.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [LAT-1:0] r_v;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_v <= '0;
      else if (w_ce[p]) r_v <= LAT'({r_v, w_re[p]});
    end

    assign w_rvalid[p] = r_v[LAT-1];

    if (LAT == 1) begin : g_l1
      assign w_rdata[p] = w_q[p];
    end else begin : g_ln
      logic [DATA_W-1:0] r_d [LAT-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LAT - 1; i++) r_d[i] <= '0;
        end else if (w_ce[p]) begin
          if (r_v[0]) r_d[0] <= w_q[p];
          for (int i = 1; i < LAT - 1; i++) if (r_v[i]) r_d[i] <= r_d[i-1];
        end
      end

      assign w_rdata[p] = r_d[LAT-2];
    end
  end

  assign a_readdata      = w_rdata[0];
  assign b_readdata      = w_rdata[1];
  assign a_readdatavalid = w_rvalid[0];
  assign b_readdatavalid = w_rvalid[1];

endmodule
